// File: rtl/mult_if_deser.sv
// Serial-to-parallel collector for the priority-mux Z stream: LSB-first words,
// optional even-parity check, and a valid/ready output slot with one hold buffer.
module mult_if_deser #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             z_valid,
    input  logic             z_sof,
    output logic             z_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             par_err,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             hold_par_q, hold_par_d;
    logic             par_err_q, par_err_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             accept;
    logic             slot_free;
    logic             complete;
    logic             word_par;
    logic [WIDTH-1:0] first_bit;
    logic [WIDTH-1:0] bit_mask;

    assign z_ready   = (state_q != HOLD);
    assign accept    = z_valid && z_ready;
    assign slot_free = !data_valid_q || data_ready;
    assign first_bit = {{(WIDTH-1){1'b0}}, z_in};
    assign bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << count_q;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shreg_d      = shreg_q;
        hold_par_d   = hold_par_q;
        data_d       = data_q;
        par_err_d    = par_err_q;
        data_valid_d = data_valid_q && !data_ready;
        frame_err_d  = 1'b0;
        complete     = 1'b0;
        word_par     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && z_sof) begin
                    shreg_d = first_bit;
                    count_d = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT, PARITY: begin
                if (accept) begin
                    if (z_sof) begin
                        // A fresh start-of-frame restarts collection with this bit as bit 0.
                        frame_err_d = 1'b1;
                        shreg_d     = first_bit;
                        count_d     = CNT_W'(1);
                        state_d     = SHIFT;
                    end else if (state_q == SHIFT) begin
                        if (z_in) begin
                            shreg_d = shreg_q | bit_mask;
                        end
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(WIDTH - 1)) begin
                            if (PARITY_EN) begin
                                state_d = PARITY;
                            end else begin
                                complete = 1'b1;
                            end
                        end
                    end else begin
                        complete = 1'b1;
                        word_par = (^shreg_q) ^ z_in;
                    end
                end
            end
            HOLD: begin
                // The finished word waits in shreg_q until the output slot drains.
                if (data_ready) begin
                    data_d       = shreg_q;
                    par_err_d    = hold_par_q;
                    data_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            count_d = '0;
            if (slot_free) begin
                data_d       = shreg_d;
                par_err_d    = word_par;
                data_valid_d = 1'b1;
                state_d      = IDLE;
            end else begin
                hold_par_d = word_par;
                state_d    = HOLD;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shreg_q      <= '0;
            hold_par_q   <= 1'b0;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            hold_par_q   <= hold_par_d;
            data_q       <= data_d;
            par_err_q    <= par_err_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/mult_if_deser.md
Name: mult_if_deser

Overview:
- Downstream consumer of the priority-mux single-bit output Z.
- Collects the serial Z stream into WIDTH-bit words, LSB first.
- Can optionally check an even-parity bit appended to each word.
- Hands each completed word to the next stage over a valid/ready handshake, so the mux side sees a bit-serial, flow-controlled interface.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- PARITY_EN, 1, 1 = one even-parity bit follows the WIDTH data bits; 0 = no parity bit.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- z_in, input, 1, serial bit (the mux Z output).
- z_valid, input, 1, z_in is valid this cycle.
- z_sof, input, 1, start of frame; qualifies z_in as data bit 0.
- z_ready, output, 1, block accepts a bit this cycle.
- data_out, output, WIDTH, assembled word.
- data_valid, output, 1, data_out and par_err are valid.
- data_ready, input, 1, downstream accepts the word.
- par_err, output, 1, parity mismatch for the word on data_out; constant 0 when PARITY_EN=0.
- frame_err, output, 1, one-cycle pulse on an aborted frame.

Behaviour:
- Reset (rst_n low, asynchronous): data_out=0, data_valid=0, par_err=0, frame_err=0, z_ready=1, state=IDLE, bit count=0, partial word discarded.
- Accept: a bit is accepted on a cycle where z_valid && z_ready. z_ready = (state != HOLD).
- IDLE:
  - Accepted bit with z_sof=1 -> stored as bit 0, count=1, go to SHIFT.
  - Accepted bit with z_sof=0 -> dropped silently, no error.
- SHIFT:
  - Accepted bit with z_sof=0 -> stored at bit[count], count+1.
  - When count reaches WIDTH: go to PARITY if PARITY_EN=1, else complete the word.
- PARITY:
  - Next accepted bit with z_sof=0 is the parity bit.
  - Error condition: XOR(word) ^ parity_bit = 1.
  - Word completes on that cycle.
- Abort: an accepted bit with z_sof=1 in SHIFT or PARITY:
  - frame_err=1 for exactly one cycle (the cycle after acceptance).
  - Partial word discarded.
  - The bit becomes bit 0 of a new frame (count=1, SHIFT).
- Completion, on the cycle the last bit is accepted:
  - If the output slot is free (!data_valid || data_ready): register the word into data_out and its parity result into par_err, data_valid=1 next cycle, go to IDLE. Latency is 1 cycle from last-bit acceptance to data_valid.
  - Otherwise: go to HOLD with the word kept internally, and z_ready=0 from the next cycle.
- HOLD: in the first cycle where data_ready=1:
  - The old word is consumed.
  - The held word loads into data_out and data_valid stays 1.
  - Go to IDLE; z_ready=1 on the following cycle.
- Output handshake:
  - data_valid stays high until data_ready.
  - data_out and par_err stay stable while data_valid && !data_ready.
  - data_valid falls after consumption unless a new word loads that same cycle.
- z_valid=0 gaps of any length inside a frame are allowed; they do not alter count or data.
- Back-to-back frames: a new z_sof bit is accepted in IDLE on the cycle after completion. There is no dead cycle beyond the IDLE transition.
- par_err is meaningful only while data_valid=1. frame_err is independent of data_valid.
- Reset asserted mid-frame or in HOLD: all state lost, no word delivered, no frame_err pulse.

Test Plan:
- WIDTH=8, PARITY_EN=1, data_ready=1; send z_sof + 0xA5 LSB-first (1,0,1,0,0,1,0,1) then parity 0 -> one cycle after the parity bit: data_valid=1, data_out=0xA5, par_err=0 for one cycle.
- Same frame with parity bit 1 -> data_out=0xA5, par_err=1.
- z_sof frame; after 3 bits reassert z_sof and send 0x3C + parity 0 -> frame_err pulses once; next delivered word is data_out=0x3C, par_err=0.
- data_ready=0; send 0x11+p0, then 0x22+p0:
  - After the second parity bit: z_ready=0 and data_out holds 0x11.
  - Raise data_ready for one cycle: 0x11 is consumed and data_out=0x22 in the same cycle, data_valid stays 1.
  - z_ready returns to 1.
- In IDLE, toggle z_valid with z_sof=0 for 5 cycles -> no data_valid, no frame_err. Then send a frame 0x5A + p0 with random z_valid gaps -> data_out=0x5A.
- Pull rst_n low after 4 bits of a frame -> data_valid, data_out, par_err and frame_err are 0 immediately and z_ready=1. After release, a full 0xC3 + p0 frame delivers data_out=0xC3.
